// File: rtl/pong_buttons_if.sv
// Button bundle between the board pads and the pong input conditioner.
//   raw_fire/raw_up/raw_dn : raw, asynchronous, bouncing button levels (pad side)
//   btn_fire               : one-cycle pulse per debounced fire press
//   fire_held              : debounced fire level
//   btn_up/btn_dn          : debounced, mutually exclusive paddle-move levels
// master: the pad/board side that drives the raw buttons and observes the results.
// slave : the conditioner itself.
interface pong_buttons_if;
  logic raw_fire;
  logic raw_up;
  logic raw_dn;
  logic btn_fire;
  logic fire_held;
  logic btn_up;
  logic btn_dn;

  modport master (
    output raw_fire, raw_up, raw_dn,
    input  btn_fire, fire_held, btn_up, btn_dn
  );

  modport slave (
    input  raw_fire, raw_up, raw_dn,
    output btn_fire, fire_held, btn_up, btn_dn
  );
endinterface

// File: rtl/pong_buttons.sv
// Input conditioning for the pong game, entirely in the clk_pix domain.
// Each of the three raw buttons is polarity-corrected, passed through a
// two-flop synchronizer and debounced by a per-button counter. The results
// are a single-cycle fire press pulse, a fire level, and up/down paddle
// levels that are forced to 0 whenever both directions are pressed.
//
// Ports:
//   clk_pix : pixel clock, the only clock
//   rst_pix : synchronous, active-high reset
//   btn     : pong_buttons_if.slave (raw_* in, btn_fire/fire_held/btn_up/btn_dn out)
//
// Parameters:
//   DB_CYCLES  : synchronized samples a new level must hold before acceptance (>= 2)
//   ACTIVE_LOW : 1 when a pressed pad reads 0
module pong_buttons #(
  parameter int DB_CYCLES  = 250_000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk_pix,
  input  logic           rst_pix,
  pong_buttons_if.slave  btn
);

  localparam int               CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam int               NB      = 3;

  // Button index: 0 = fire, 1 = up, 2 = down.
  localparam int B_FIRE = 0;
  localparam int B_UP   = 1;
  localparam int B_DN   = 2;

  logic [NB-1:0]    raw_pol;
  logic [NB-1:0]    s1_q;
  logic [NB-1:0]    s2_q;
  logic [NB-1:0]    stable_q;
  logic [NB-1:0]    stable_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic             btn_fire_q;
  logic             btn_up_q;
  logic             btn_dn_q;

  // Polarity is applied on the pad side, so everything downstream treats
  // 1 as pressed and the synchronizer resets to the logical-inactive value.
  assign raw_pol = {btn.raw_dn, btn.raw_up, btn.raw_fire} ^ {NB{ACTIVE_LOW}};

  // Debounce: any sample matching the accepted level restarts the count;
  // a new level is accepted only after DB_CYCLES consecutive disagreeing
  // samples, so the counter never passes CNT_MAX and never wraps.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      btn_fire_q <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_dn_q   <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw_pol;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      // Rising edge of the accepted fire level only; holding or releasing
      // gives no further pulse.
      btn_fire_q <= stable_d[B_FIRE] & ~stable_q[B_FIRE];
      // Built from next-state levels so the moves change on the same edge
      // as the accepted levels themselves.
      btn_up_q   <= stable_d[B_UP] & ~stable_d[B_DN];
      btn_dn_q   <= stable_d[B_DN] & ~stable_d[B_UP];
    end
  end

  assign btn.btn_fire  = btn_fire_q;
  assign btn.fire_held = stable_q[B_FIRE];
  assign btn.btn_up    = btn_up_q;
  assign btn.btn_dn    = btn_dn_q;

endmodule

// File: tb/tb_pong_buttons.sv
// Self-checking bench for pong_buttons with DB_CYCLES=4: one instance with
// active-high pads, one with active-low pads. A window-based reference model
// predicts every cycle's outputs; predictions are queued at the edge the
// stimulus is sampled and compared just after that edge. Directed checks
// with fixed expectations cover the latency points of each scenario.
module tb_pong_buttons;
  localparam int DB = 4;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;

  always #5 clk_pix = ~clk_pix;

  pong_buttons_if ifa ();
  pong_buttons_if ifb ();

  pong_buttons #(.DB_CYCLES(DB), .ACTIVE_LOW(1'b0)) dut_a (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .btn     (ifa.slave)
  );

  pong_buttons #(.DB_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut_b (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .btn     (ifb.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state per instance d and button i (0 fire, 1 up, 2 dn).
  logic       m_s1  [2][3];
  logic       m_s2  [2][3];
  logic       m_st  [2][3];
  logic       m_win [2][3][DB];
  logic [3:0] m_out [2];

  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A level is accepted once the last DB synchronized samples all disagree
  // with the currently accepted level.
  task automatic model_edge(input int d, input logic [2:0] rawp, input logic rst);
    logic [2:0] nst;
    bit         all_diff;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[d][i] = 1'b0;
        m_s2[d][i] = 1'b0;
        m_st[d][i] = 1'b0;
        for (int k = 0; k < DB; k++) m_win[d][i][k] = 1'b0;
      end
      m_out[d] = 4'b0000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int k = DB - 1; k > 0; k--) m_win[d][i][k] = m_win[d][i][k-1];
        m_win[d][i][0] = m_s2[d][i];
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (m_win[d][i][k] == m_st[d][i]) all_diff = 1'b0;
        nst[i] = all_diff ? ~m_st[d][i] : m_st[d][i];
        m_s2[d][i] = m_s1[d][i];
        m_s1[d][i] = rawp[i];
      end
      m_out[d] = {nst[0] & ~m_st[d][0], nst[0], nst[1] & ~nst[2], nst[2] & ~nst[1]};
      for (int i = 0; i < 3; i++) m_st[d][i] = nst[i];
    end
  endtask

  // One clock edge: predict from the inputs the DUTs sample, then compare.
  task automatic step();
    logic [2:0] ra, rb;
    logic [7:0] e;
    @(posedge clk_pix);
    ra = {ifa.raw_dn, ifa.raw_up, ifa.raw_fire};
    rb = ~{ifb.raw_dn, ifb.raw_up, ifb.raw_fire};
    model_edge(0, ra, rst_pix);
    model_edge(1, rb, rst_pix);
    exp_q.push_back({m_out[1], m_out[0]});
    #1;
    e = exp_q.pop_front();
    check("a_outs", {ifa.btn_fire, ifa.fire_held, ifa.btn_up, ifa.btn_dn}, e[3:0]);
    check("b_outs", {ifb.btn_fire, ifb.fire_held, ifb.btn_up, ifb.btn_dn}, e[7:4]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [3:0] outs_a();
    return {ifa.btn_fire, ifa.fire_held, ifa.btn_up, ifa.btn_dn};
  endfunction

  initial begin
    logic [9:0] bounce;
    bounce = 10'b1111110111;  // bit e = raw_fire on edge e: 1,1,1,0,1,1,1,1,1,1

    ifa.raw_fire = 1'b1; ifa.raw_up = 1'b1; ifa.raw_dn = 1'b1;
    ifb.raw_fire = 1'b1; ifb.raw_up = 1'b1; ifb.raw_dn = 1'b1;

    // 1. Reset with all buttons pressed, then fresh detection after release.
    rst_pix = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      check("t1_in_reset", outs_a(), 4'b0000);
    end
    rst_pix = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 0) check("t1_first_edge", outs_a(), 4'b0000);
      if (e == 4) check("t1_held_e4", ifa.fire_held, 1'b0);
      if (e == 5) check("t1_e5", outs_a(), 4'b1100);
      if (e == 6) check("t1_e6", outs_a(), 4'b0100);
    end
    ifa.raw_fire = 1'b0; ifa.raw_up = 1'b0; ifa.raw_dn = 1'b0;
    run(10);

    // 2. Clean fire press held 30 cycles, then release.
    for (int e = 0; e < 42; e++) begin
      ifa.raw_fire = (e < 30);
      step();
      if (e == 4)  check("t2_held_e4", ifa.fire_held, 1'b0);
      if (e == 5)  check("t2_press_e5", {ifa.btn_fire, ifa.fire_held}, 2'b11);
      if (e == 6)  check("t2_pulse_e6", {ifa.btn_fire, ifa.fire_held}, 2'b01);
      if (e == 34) check("t2_held_e34", ifa.fire_held, 1'b1);
      if (e >= 30 && e <= 36) check("t2_no_rel_pulse", ifa.btn_fire, 1'b0);
      if (e == 35) check("t2_release_e35", ifa.fire_held, 1'b0);
    end

    // 3. Bounce.
    for (int e = 0; e < 15; e++) begin
      ifa.raw_fire = (e < 10) ? bounce[e] : 1'b1;
      step();
      if (e <= 8)  check("t3_quiet", {ifa.btn_fire, ifa.fire_held}, 2'b00);
      if (e == 9)  check("t3_accept_e9", {ifa.btn_fire, ifa.fire_held}, 2'b11);
      if (e == 10) check("t3_pulse_end", {ifa.btn_fire, ifa.fire_held}, 2'b01);
    end
    ifa.raw_fire = 1'b0;
    run(10);

    // 4. Up/down exclusion.
    for (int e = 0; e < 30; e++) begin
      ifa.raw_up = 1'b1;
      ifa.raw_dn = (e < 20);
      step();
      if (e < 25)  check("t4_both_zero", {ifa.btn_up, ifa.btn_dn}, 2'b00);
      if (e == 25) check("t4_up_e25", {ifa.btn_up, ifa.btn_dn}, 2'b10);
    end
    ifa.raw_up = 1'b0;
    run(10);

    // 5. Active-low instance.
    check("t5_idle", {ifb.btn_fire, ifb.fire_held, ifb.btn_up, ifb.btn_dn}, 4'b0000);
    for (int e = 0; e < 10; e++) begin
      ifb.raw_up = 1'b0;
      step();
      if (e == 4) check("t5_up_e4", ifb.btn_up, 1'b0);
      if (e == 5) check("t5_up_e5", ifb.btn_up, 1'b1);
    end
    ifb.raw_up = 1'b1;
    run(10);

    // 6. Reset in the middle of a hold.
    for (int e = 0; e < 25; e++) begin
      ifa.raw_fire = 1'b1;
      rst_pix = (e == 10 || e == 11);
      step();
      if (e == 5)  check("t6_pulse1", {ifa.btn_fire, ifa.fire_held}, 2'b11);
      if (e == 10) check("t6_reset", outs_a(), 4'b0000);
      if (e == 16) check("t6_held_e16", ifa.fire_held, 1'b0);
      if (e == 17) check("t6_pulse2", {ifa.btn_fire, ifa.fire_held}, 2'b11);
      if (e == 18) check("t6_pulse2_end", {ifa.btn_fire, ifa.fire_held}, 2'b01);
    end
    rst_pix = 1'b0;
    ifa.raw_fire = 1'b0;
    run(10);

    // Random bouncing on all buttons of both instances, rare resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) ifa.raw_fire = ~ifa.raw_fire;
      if ($urandom_range(5) == 0) ifa.raw_up   = ~ifa.raw_up;
      if ($urandom_range(5) == 0) ifa.raw_dn   = ~ifa.raw_dn;
      if ($urandom_range(5) == 0) ifb.raw_fire = ~ifb.raw_fire;
      if ($urandom_range(5) == 0) ifb.raw_up   = ~ifb.raw_up;
      if ($urandom_range(5) == 0) ifb.raw_dn   = ~ifb.raw_dn;
      rst_pix = ($urandom_range(99) == 0);
      step();
    end
    rst_pix = 1'b0;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
